// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-ported unified memory between the instruction-fetch
// stage (IF) and the data-memory stage (MEM). One access is in flight at a
// time. MEM normally wins a contended grant. After STARVE_MAX contended MEM
// grants in a row, IF wins once. A flush discards the outstanding fetch
// response without aborting the memory access.
//
// Ports
//   Clock, Resetn              : clock, asynchronous active-low reset
//   if_req/if_addr/if_flush    : fetch request, address, discard request
//   if_rdata/if_ready          : fetch completion pulse and data
//   dm_req/dm_we/dm_addr/
//   dm_wdata                   : data request, write enable, address, data
//   dm_rdata/dm_ready          : data completion pulse and read data
//   m_req/m_we/m_addr/m_wdata  : memory request, held until m_ack
//   m_rdata/m_ack              : memory read data and completion pulse
//   busy                       : high whenever the arbiter is not idle
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | sample requests and grant one
// BUSY_IF | fetch access presented to memory, waiting for m_ack
// BUSY_DM | data access presented to memory, waiting for m_ack
// RESP    | one-cycle ready pulse to the owner, then back to IDLE

module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack,
    output logic              busy
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_DM = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    state_t            state_q,      state_d;
    logic              owner_if_q,   owner_if_d;
    logic              drop_q,       drop_d;
    logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
    logic              m_we_q,       m_we_d;
    logic [ADDR_W-1:0] m_addr_q,     m_addr_d;
    logic [DATA_W-1:0] m_wdata_q,    m_wdata_d;
    logic [DATA_W-1:0] rdata_q,      rdata_d;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q      <= ST_IDLE;
            owner_if_q   <= 1'b0;
            drop_q       <= 1'b0;
            starve_cnt_q <= '0;
            m_we_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_if_q   <= owner_if_d;
            drop_q       <= drop_d;
            starve_cnt_q <= starve_cnt_d;
            m_we_q       <= m_we_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_if_d   = owner_if_q;
        drop_d       = drop_q;
        starve_cnt_d = starve_cnt_q;
        m_we_d       = m_we_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        rdata_d      = rdata_q;

        case (state_q)
            ST_IDLE: begin
                // IF wins when it is the only requester, or when MEM has
                // already taken STARVE_MAX contended grants in a row.
                if (if_req && (!dm_req || (starve_cnt_q == STARVE_LIM))) begin
                    state_d      = ST_BUSY_IF;
                    owner_if_d   = 1'b1;
                    m_we_d       = 1'b0;
                    m_addr_d     = if_addr;
                    m_wdata_d    = '0;
                    starve_cnt_d = '0;
                end else if (dm_req) begin
                    state_d    = ST_BUSY_DM;
                    owner_if_d = 1'b0;
                    m_we_d     = dm_we;
                    m_addr_d   = dm_addr;
                    m_wdata_d  = dm_wdata;
                    if (if_req && (starve_cnt_q != STARVE_LIM)) begin
                        starve_cnt_d = starve_cnt_q + SW'(1);
                    end
                end
            end
            ST_BUSY_IF: begin
                if (if_flush) begin
                    drop_d = 1'b1;
                end
                if (m_ack) begin
                    rdata_d = m_we_q ? '0 : m_rdata;
                    state_d = ST_RESP;
                end
            end
            ST_BUSY_DM: begin
                if (m_ack) begin
                    rdata_d = m_we_q ? '0 : m_rdata;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                drop_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A flush arriving in the response cycle itself suppresses the pulse
    // directly; holding drop past RESP would wrongly eat the next fetch.
    assign if_ready = (state_q == ST_RESP) && owner_if_q && !drop_q && !if_flush;
    assign dm_ready = (state_q == ST_RESP) && !owner_if_q;
    assign if_rdata = if_ready ? rdata_q : '0;
    assign dm_rdata = dm_ready ? rdata_q : '0;

    assign m_req   = (state_q == ST_BUSY_IF) || (state_q == ST_BUSY_DM);
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign busy    = (state_q != ST_IDLE);

endmodule
